// File: rtl/emu_time_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// emu_time_ctrl_pkg
// Shared types for the emulation time controller: command modes, FSM states
// and the decoder that folds reserved mode codes onto FREE.
// No ports (package).
// ----------------------------------------------------------------------------
package emu_time_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_FREE     = 3'd0,
        MODE_STALL    = 3'd1,
        MODE_STOP_AT  = 3'd2,
        MODE_FIXED_DT = 3'd3,
        MODE_STEP_N   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BOUNDED = 2'd1,
        ST_STALLED = 2'd2
    } state_e;

    // Codes 5..7 are reserved and behave exactly like FREE.
    function automatic mode_e decode_mode(input logic [2:0] raw);
        if (raw > 3'd4) begin
            return MODE_FREE;
        end
        return mode_e'(raw);
    endfunction

endpackage

// File: rtl/emu_time_ctrl_if.sv
// ----------------------------------------------------------------------------
// emu_time_ctrl_if
// Command channel into the time controller (valid/ready handshake).
// Signals:
//   ctrl_valid  command present            (master -> slave)
//   ctrl_ready  command can be accepted    (slave  -> master)
//   ctrl_mode   command mode, 3 bits       (master -> slave)
//   ctrl_data   command operand            (master -> slave)
// ----------------------------------------------------------------------------
interface emu_time_ctrl_if #(
    parameter int TIME_WIDTH = 32
);
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic [2:0]            ctrl_mode;
    logic [TIME_WIDTH-1:0] ctrl_data;

    modport master (
        output ctrl_valid,
        output ctrl_mode,
        output ctrl_data,
        input  ctrl_ready
    );

    modport slave (
        input  ctrl_valid,
        input  ctrl_mode,
        input  ctrl_data,
        output ctrl_ready
    );
endinterface

// File: rtl/emu_time_ctrl_dec_chan.sv
// ----------------------------------------------------------------------------
// emu_dec_chan
// One decimation channel: an up-counter that strobes when it equals the
// threshold and wraps to 0 on that match. Holds while disabled.
// Ports:
//   emu_clk, emu_rst_n  clock / async active-low reset
//   en                  advance enable (emulation not stalled)
//   thr                 match threshold
//   cmp                 sample strobe (match while enabled)
// ----------------------------------------------------------------------------
module emu_dec_chan #(
    parameter int DEC_WIDTH = 16
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic                 en,
    input  logic [DEC_WIDTH-1:0] thr,
    output logic                 cmp
);
    logic [DEC_WIDTH-1:0] cnt_q;
    logic                 match;

    assign match = (cnt_q == thr);
    assign cmp   = match && en;

    // A threshold lowered below cnt_q simply misses until the counter wraps.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= match ? '0 : cnt_q + DEC_WIDTH'(1);
        end
    end
endmodule

// File: rtl/emu_time_ctrl.sv
// ----------------------------------------------------------------------------
// emu_time_ctrl
// Emulation time controller: turns accepted commands into a per-cycle
// timestep request and drives N_DEC decimation strobes.
// Ports:
//   emu_clk, emu_rst_n  clock / async active-low reset
//   ctrl                command channel (slave modport)
//   emu_time            current emulation time
//   dec_thr             per-channel thresholds, channel i at [i*DEC_WIDTH +: DEC_WIDTH]
//   dt_req              timestep request (0 = stall)
//   dec_cmp             per-channel sample strobes
//   emu_stalled         dt_req == 0
//   step_done           one-cycle pulse when a bounded run finishes
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | free running: dt_max (FREE) or saturated cmd_data (FIXED_DT)
// ST_BOUNDED | STOP_AT target or STEP_N count in progress
// ST_STALLED | dt_req held at 0 until the next command
// ----------------------------------------------------------------------------
module emu_time_ctrl
    import emu_time_ctrl_pkg::*;
#(
    parameter int TIME_WIDTH = 32,
    parameter int DT_WIDTH   = 27,
    parameter int DEC_WIDTH  = 16,
    parameter int N_DEC      = 2
) (
    input  logic                       emu_clk,
    input  logic                       emu_rst_n,
    emu_time_ctrl_if.slave             ctrl,
    input  logic [TIME_WIDTH-1:0]      emu_time,
    input  logic [N_DEC*DEC_WIDTH-1:0] dec_thr,
    output logic [DT_WIDTH-1:0]        dt_req,
    output logic [N_DEC-1:0]           dec_cmp,
    output logic                       emu_stalled,
    output logic                       step_done
);
    localparam logic [DT_WIDTH-1:0]   DT_MAX   = '1;
    localparam logic [TIME_WIDTH-1:0] DT_MAX_T = TIME_WIDTH'(DT_MAX);

    state_e                state_q, state_d;
    mode_e                 cmd_mode;
    logic [TIME_WIDTH-1:0] cmd_data;
    logic [TIME_WIDTH-1:0] step_cnt;
    logic                  ready_q;
    logic                  done_q, done_d;
    logic                  accept;
    logic [TIME_WIDTH-1:0] dt_wide;
    logic [TIME_WIDTH-1:0] remaining;

    assign accept          = ctrl.ctrl_valid && ready_q;
    assign ctrl.ctrl_ready = ready_q;
    assign remaining       = cmd_data - emu_time;

    // Timestep computed at TIME_WIDTH and saturated to dt_max, so the
    // upper bits are always zero and the low slice is the request.
    always_comb begin
        dt_wide = '0;
        case (state_q)
            ST_RUN: begin
                if (cmd_mode == MODE_FIXED_DT) begin
                    dt_wide = (cmd_data > DT_MAX_T) ? DT_MAX_T : cmd_data;
                end else begin
                    dt_wide = DT_MAX_T;
                end
            end
            ST_BOUNDED: begin
                if (cmd_mode == MODE_STOP_AT) begin
                    if (cmd_data > emu_time) begin
                        dt_wide = (remaining > DT_MAX_T) ? DT_MAX_T : remaining;
                    end
                end else if (step_cnt != '0) begin
                    dt_wide = DT_MAX_T;
                end
            end
            default: dt_wide = '0;
        endcase
    end

    assign dt_req      = dt_wide[DT_WIDTH-1:0];
    assign emu_stalled = (dt_wide == '0);
    assign step_done   = done_q;

    // A fresh command always wins, so an overridden bounded run never
    // reports completion.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (accept) begin
            case (decode_mode(ctrl.ctrl_mode))
                MODE_STALL:                 state_d = ST_STALLED;
                MODE_STOP_AT, MODE_STEP_N:  state_d = ST_BOUNDED;
                default:                    state_d = ST_RUN;
            endcase
        end else if (state_q == ST_BOUNDED && dt_wide == '0) begin
            state_d = ST_STALLED;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q  <= ST_RUN;
            cmd_mode <= MODE_FREE;
            cmd_data <= '0;
            step_cnt <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ready_q <= !accept;
            if (accept) begin
                cmd_mode <= decode_mode(ctrl.ctrl_mode);
                cmd_data <= ctrl.ctrl_data;
                step_cnt <= ctrl.ctrl_data;
            end else if (state_q == ST_BOUNDED && cmd_mode == MODE_STEP_N
                         && step_cnt != '0) begin
                step_cnt <= step_cnt - TIME_WIDTH'(1);
            end
        end
    end

    for (genvar i = 0; i < N_DEC; i++) begin : g_dec
        emu_dec_chan #(
            .DEC_WIDTH(DEC_WIDTH)
        ) u_chan (
            .emu_clk   (emu_clk),
            .emu_rst_n (emu_rst_n),
            .en        (!emu_stalled),
            .thr       (dec_thr[i*DEC_WIDTH +: DEC_WIDTH]),
            .cmp       (dec_cmp[i])
        );
    end
endmodule

// File: doc/emu_time_ctrl.md
EMU_TIME_CTRL -- requirements
Module: emu_time_ctrl

Interface
REQ-001 The module SHALL have one clock, emu_clk, and an asynchronous, active-low reset, emu_rst_n.
REQ-002 Parameter TIME_WIDTH, default 32: width of the emulation time and command data.
REQ-003 Parameter DT_WIDTH, default 27: width of the timestep request; DT_WIDTH SHALL be <= TIME_WIDTH.
REQ-004 Parameter DEC_WIDTH, default 16: width of each decimation counter and threshold.
REQ-005 Parameter N_DEC, default 2: number of independent decimation channels, >= 1.
REQ-006 Port emu_clk, input, 1: emulator clock.
REQ-007 Port emu_rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port ctrl_valid, input, 1: command present.
REQ-009 Port ctrl_ready, output, 1: command can be accepted.
REQ-010 Port ctrl_mode, input, 3: command mode.
REQ-011 Port ctrl_data, input, TIME_WIDTH: command operand.
REQ-012 Port emu_time, input, TIME_WIDTH: current emulation time.
REQ-013 Port dec_thr, input, N_DEC*DEC_WIDTH: per-channel decimation thresholds, with channel i at bits [i*DEC_WIDTH +: DEC_WIDTH].
REQ-014 Port dt_req, output, DT_WIDTH: timestep request.
REQ-015 Port dec_cmp, output, N_DEC: per-channel sample strobe.
REQ-016 Port emu_stalled, output, 1: high when dt_req == 0.
REQ-017 Port step_done, output, 1: one-cycle pulse when a bounded run completes.

Function
REQ-018 Modes: 0 FREE, 1 STALL, 2 STOP_AT, 3 FIXED_DT, 4 STEP_N; codes 5-7 SHALL be treated as FREE.
REQ-019 A command SHALL be accepted on a rising edge with ctrl_valid && ctrl_ready; ctrl_mode and ctrl_data SHALL be latched into cmd_mode/cmd_data and take effect the following cycle.
REQ-020 ctrl_ready SHALL be low in the cycle after an accept and high otherwise, limiting throughput to one command per two cycles.
REQ-021 The FSM SHALL have states RUN, BOUNDED, STALLED.
REQ-022 FREE and FIXED_DT SHALL enter RUN; STALL SHALL enter STALLED; STOP_AT and STEP_N SHALL enter BOUNDED.
REQ-023 dt_max SHALL be all-ones at DT_WIDTH.
REQ-024 dt_req in RUN/FREE SHALL be dt_max.
REQ-025 dt_req in RUN/FIXED_DT SHALL be min(cmd_data, dt_max), with the comparison done at TIME_WIDTH.
REQ-026 dt_req in STALLED SHALL be 0.
REQ-027 dt_req in BOUNDED/STOP_AT SHALL be combinational on live emu_time: cmd_data > emu_time ? min(cmd_data - emu_time, dt_max) : 0.
REQ-028 In BOUNDED/STOP_AT, a dt_req of 0 SHALL move the FSM to STALLED on the next edge.
REQ-029 In BOUNDED/STEP_N, a step counter SHALL be loaded with cmd_data on accept; dt_req SHALL be dt_max while the counter is nonzero, and the counter SHALL decrement each cycle.
REQ-030 When the STEP_N counter reaches 0, the FSM SHALL move to STALLED; a load of 0 SHALL give dt_req = 0 and STALLED on the next edge.
REQ-031 step_done SHALL pulse for exactly one cycle on the BOUNDED->STALLED transition only.
REQ-032 A new accepted command SHALL override any state, including BOUNDED mid-run, with no step_done pulse.
REQ-033 Per channel i, dec_cmp[i] SHALL equal (cnt_i == thr_i) && !emu_stalled.
REQ-034 Each cnt_i SHALL advance only when !emu_stalled, wrapping to 0 on a match.
REQ-035 When stalled, cnt_i SHALL hold its value.
REQ-036 A threshold of 0 SHALL strobe dec_cmp[i] on every non-stalled cycle.
REQ-037 A threshold reduced below the current cnt_i SHALL cause cnt_i to count up through its 2^DEC_WIDTH wrap before matching.

Reset
REQ-038 On emu_rst_n low, all state SHALL clear asynchronously: FSM=RUN, cmd_mode=FREE, cmd_data=0, step counter=0, cnt_i=0, ctrl_ready=1, step_done=0.
REQ-039 During reset, dt_req SHALL be dt_max, emu_stalled 0, and dec_cmp derived per REQ-033 from cnt_i=0.
REQ-040 A reset asserted mid-STEP_N or mid-STOP_AT SHALL abandon the run with no step_done pulse.

Structure
REQ-041 Package emu_time_ctrl_pkg SHALL hold the mode enum (FREE..STEP_N) and the FSM state enum.
REQ-042 One sub-module, emu_dec_chan, SHALL implement a single decimation counter and comparator, instantiated N_DEC times by generate.

Verification
REQ-043 Reset, then FREE with thr={0,3}: dt_req=2^27-1; dec_cmp[0] every cycle; dec_cmp[1] every 4th cycle.
REQ-044 STOP_AT 1000 with emu_time=990 and time advancing by dt_req: dt_req=10, then 0; emu_stalled=1; one step_done pulse; emu_time stays 1000.
REQ-045 STEP_N 5: exactly 5 cycles of dt_max, then stall with step_done; STEP_N 0: stall the next cycle.
REQ-046 FIXED_DT 2^30 -> dt_req=2^27-1 (saturated); FIXED_DT 7 -> dt_req=7.
REQ-047 STALL with thr=3 and cnt=2: cnt holds and dec_cmp=0; FREE resumes, and dec_cmp fires 2 cycles later.
REQ-048 STEP_N 100 with reset pulsed at step 40: outputs return to reset values immediately, no step_done, dt_req=dt_max.
